// File: rtl/jtag_scan_master.sv
// jtag_scan_master
//   Host-side JTAG scan engine. Drives TCK/TMS/TDI into an IEEE 1149.1 TAP,
//   captures TDO, and runs one IR or DR scan (1..DR_WIDTH bits) per command.
//   After every reset it walks the TAP to Test-Logic-Reset and then to
//   Run-Test/Idle before it accepts commands.
//
// Ports
//   clk        system clock (the only clock)
//   reset_n    synchronous, active-low reset
//   cmd_valid  command offered           cmd_ready  engine idle, can accept
//   cmd_ir     1 = IR scan, 0 = DR scan   cmd_len    bits to shift
//   cmd_data   TDI data, LSB shifted first
//   rsp_valid  one-cycle completion pulse
//   rsp_data   captured TDO bits, right-justified
//   rsp_err    qualifies rsp_valid: command was illegal
//   tck/tms/tdi  JTAG outputs            tdo        JTAG input from the TAP
module jtag_scan_master #(
    parameter int CLK_DIV  = 2,
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_ir,
    input  logic [5:0]          cmd_len,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                rsp_err,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [5:0]  DR_LEN   = 6'(DR_WIDTH);
    localparam logic [5:0]  IR_LEN   = 6'(IR_WIDTH);

    // state_reg is the shadow TAP position; the pending TCK edge leaves it.
    // IDLE is Run-Test/Idle; armed_reg marks that a scan's first edge is pending.
    typedef enum logic [3:0] {
        TLR_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RSP
    } state_t;

    state_t                state_reg;
    logic [15:0]           div_cnt_reg;
    logic [2:0]            tlr_cnt_reg;
    logic [5:0]            bit_cnt_reg;
    logic                  armed_reg;
    logic                  ir_reg;
    logic [5:0]            len_reg;
    logic [DR_WIDTH-1:0]   data_reg;
    logic [DR_WIDTH-1:0]   cap_reg;

    logic cmd_illegal;
    logic last_bit;
    logic half_done;
    logic tms_next;
    logic tdi_next;

    assign cmd_illegal = (cmd_len == 6'd0) || (cmd_len > DR_LEN) ||
                         (cmd_ir && (cmd_len > IR_LEN));
    assign last_bit    = (bit_cnt_reg == (len_reg - 6'd1));
    assign half_done   = (div_cnt_reg == DIV_LAST);

    // TMS/TDI for the next rising edge, evaluated from the already-advanced
    // shadow state and applied on the falling edge.
    always_comb begin
        tms_next = 1'b0;
        tdi_next = 1'b0;
        case (state_reg)
            TLR_SEQ: tms_next = (tlr_cnt_reg < 3'd5);
            SEL_DR:  tms_next = ir_reg;      // second 1 heads to Select-IR
            SHIFT: begin
                tms_next = last_bit;
                tdi_next = data_reg[bit_cnt_reg];
            end
            EXIT1:   tms_next = 1'b1;
            default: tms_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= TLR_SEQ;
            div_cnt_reg <= '0;
            tlr_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            armed_reg   <= 1'b0;
            ir_reg      <= 1'b0;
            len_reg     <= '0;
            data_reg    <= '0;
            cap_reg     <= '0;
            tck         <= 1'b0;
            tms         <= 1'b1;
            tdi         <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_data    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (state_reg == IDLE && !armed_reg) begin
                tck <= 1'b0;
                tms <= 1'b0;
                tdi <= 1'b0;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready <= 1'b0;
                    if (cmd_illegal) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                    end else begin
                        armed_reg   <= 1'b1;
                        ir_reg      <= cmd_ir;
                        len_reg     <= cmd_len;
                        data_reg    <= cmd_data;
                        cap_reg     <= '0;
                        bit_cnt_reg <= '0;
                        div_cnt_reg <= '0;
                        tms         <= 1'b1;   // first edge: to Select-DR
                    end
                end else begin
                    cmd_ready <= 1'b1;
                end
            end else if (!half_done) begin
                div_cnt_reg <= div_cnt_reg + 16'd1;
            end else begin
                div_cnt_reg <= '0;
                if (!tck) begin
                    // Rising edge: TAP moves, TDO is sampled.
                    tck <= 1'b1;
                    case (state_reg)
                        TLR_SEQ: tlr_cnt_reg <= tlr_cnt_reg + 3'd1;
                        IDLE: begin
                            armed_reg <= 1'b0;
                            state_reg <= SEL_DR;
                        end
                        SEL_DR:  state_reg <= ir_reg ? SEL_IR : CAPTURE;
                        SEL_IR:  state_reg <= CAPTURE;
                        CAPTURE: begin
                            state_reg   <= SHIFT;
                            bit_cnt_reg <= '0;
                        end
                        SHIFT: begin
                            cap_reg[bit_cnt_reg] <= tdo;
                            if (last_bit)
                                state_reg <= EXIT1;
                            else
                                bit_cnt_reg <= bit_cnt_reg + 6'd1;
                        end
                        EXIT1:   state_reg <= UPDATE;
                        UPDATE:  state_reg <= RSP;
                        default: state_reg <= state_reg;
                    endcase
                end else begin
                    // Falling edge: present TMS/TDI for the next rise.
                    tck <= 1'b0;
                    tms <= tms_next;
                    tdi <= tdi_next;
                    if (state_reg == TLR_SEQ && tlr_cnt_reg == 3'd6)
                        state_reg <= IDLE;
                    if (state_reg == RSP) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= cap_reg;
                        state_reg <= IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master: a behavioural TAP on instance "a"
// (CLK_DIV=2) and a second instance "b" (CLK_DIV=1) for back-to-back commands.
module tb_jtag_scan_master;

    logic        clk = 1'b0;
    logic        reset_n;
    always #5 clk = ~clk;

    // instance a
    logic        cmd_valid, cmd_ready, cmd_ir;
    logic [5:0]  cmd_len;
    logic [37:0] cmd_data;
    logic        rsp_valid, rsp_err;
    logic [37:0] rsp_data;
    logic        tck, tms, tdi;
    logic        tdo = 1'b0;

    // instance b
    logic        b_cmd_valid, b_cmd_ready, b_cmd_ir;
    logic [5:0]  b_cmd_len;
    logic [37:0] b_cmd_data;
    logic        b_rsp_valid, b_rsp_err;
    logic [37:0] b_rsp_data;
    logic        b_tck, b_tms, b_tdi;
    logic        b_tdo;
    assign b_tdo = 1'b0;

    jtag_scan_master #(.CLK_DIV(2), .DR_WIDTH(38), .IR_WIDTH(10)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    jtag_scan_master #(.CLK_DIV(1), .DR_WIDTH(38), .IR_WIDTH(10)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_ir(b_cmd_ir),
        .cmd_len(b_cmd_len), .cmd_data(b_cmd_data),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
        .tck(b_tck), .tms(b_tms), .tdi(b_tdi), .tdo(b_tdo)
    );

    // ---------------- behavioural TAP on instance a ----------------
    localparam int T_TLR = 0, T_RTI = 1, T_SDR = 2, T_CDR = 3, T_SHDR = 4,
                   T_E1DR = 5, T_PDR = 6, T_E2DR = 7, T_UDR = 8, T_SIR = 9,
                   T_CIR = 10, T_SHIR = 11, T_E1IR = 12, T_PIR = 13,
                   T_E2IR = 14, T_UIR = 15;

    int          tap_state = T_TLR;
    logic [37:0] dr_cap = '0;
    logic [37:0] dr_sr = '0, dr_upd = '0;
    logic [9:0]  ir_sr = '0, ir_q = '0;

    function automatic int tap_next(input int s, input logic m);
        case (s)
            T_TLR:  return m ? T_TLR  : T_RTI;
            T_RTI:  return m ? T_SDR  : T_RTI;
            T_SDR:  return m ? T_SIR  : T_CDR;
            T_CDR:  return m ? T_E1DR : T_SHDR;
            T_SHDR: return m ? T_E1DR : T_SHDR;
            T_E1DR: return m ? T_UDR  : T_PDR;
            T_PDR:  return m ? T_E2DR : T_PDR;
            T_E2DR: return m ? T_UDR  : T_SHDR;
            T_UDR:  return m ? T_SDR  : T_RTI;
            T_SIR:  return m ? T_TLR  : T_CIR;
            T_CIR:  return m ? T_E1IR : T_SHIR;
            T_SHIR: return m ? T_E1IR : T_SHIR;
            T_E1IR: return m ? T_UIR  : T_PIR;
            T_PIR:  return m ? T_E2IR : T_PIR;
            T_E2IR: return m ? T_UIR  : T_SHIR;
            default: return m ? T_SDR : T_RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap_state)
            T_CDR:  dr_sr  <= dr_cap;
            T_SHDR: dr_sr  <= {tdi, dr_sr[37:1]};
            T_UDR:  dr_upd <= dr_sr;
            T_CIR:  ir_sr  <= 10'h001;
            T_SHIR: ir_sr  <= {tdi, ir_sr[9:1]};
            T_UIR:  ir_q   <= ir_sr;
            default: ;
        endcase
        tap_state <= tap_next(tap_state, tms);
    end

    always @(negedge tck)
        tdo <= (tap_state == T_SHDR) ? dr_sr[0] :
               (tap_state == T_SHIR) ? ir_sr[0] : 1'b0;

    // ---------------- monitors (sampled on falling clk) ----------------
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   edges = 0, rsp_cnt = 0, b_edges = 0, b_rsp_cnt = 0;
    logic tck_q = 1'b0, b_tck_q = 1'b0;
    logic tms_log [1024];
    int   rise_log [1024];

    always @(negedge clk) begin
        if (tck && !tck_q) begin
            tms_log[edges % 1024]  <= tms;
            rise_log[edges % 1024] <= cyc;
            edges <= edges + 1;
        end
        tck_q <= tck;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (b_tck && !b_tck_q) b_edges <= b_edges + 1;
        b_tck_q <= b_tck;
        if (b_rsp_valid) b_rsp_cnt <= b_rsp_cnt + 1;
    end

    // ---------------- checking helpers ----------------
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] tms_obs(input int base, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n && i < 64; i++) v[i] = tms_log[(base + i) % 1024];
        return v;
    endfunction

    function automatic logic [63:0] tms_exp(input logic ir, input int len);
        logic [63:0] v = '0;
        int p = 0;
        v[p] = 1'b1; p++;               // Select-DR
        if (ir) begin v[p] = 1'b1; p++; end   // Select-IR
        p += 2;                         // Capture, Shift
        p += len - 1;                   // shift bits with tms=0
        v[p] = 1'b1; p++;               // last bit -> Exit1
        v[p] = 1'b1;                    // Update, then 0 -> Run-Test/Idle
        return v;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
        chk(tag, 64'(cmd_ready), 64'd1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 1000);
        chk("rsp_seen", 64'(rsp_valid), 64'd1);
    endtask

    task automatic send(input logic ir, input logic [5:0] len, input logic [37:0] data);
        cmd_ir = ir; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        // scrambled after acceptance: must not affect the running scan
        cmd_ir = ~ir; cmd_len = 6'd3; cmd_data = ~data;
        $display("txn a: ir=%0d len=%0d data=%h", ir, len, data);
    endtask

    // ---------------- directed sequence ----------------
    int n, base, rbase, bad, ready_cycles;
    logic [5:0]  ill_len [3] = '{6'd0, 6'd11, 6'd39};
    logic        ill_ir  [3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_ir = 1'b0; cmd_len = '0; cmd_data = '0;
        b_cmd_valid = 1'b0; b_cmd_ir = 1'b0; b_cmd_len = '0; b_cmd_data = '0;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_tck", 64'(tck), 64'd0);
        chk("rst_tms", 64'(tms), 64'd1);
        chk("rst_tdi", 64'(tdi), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);

        // TLR sequence after reset release
        base = edges; rbase = rsp_cnt;
        reset_n = 1'b1;
        wait_ready("tlr_ready");
        $display("txn a: reset sequence, %0d edges", edges - base);
        chk("tlr_edges", 64'(edges - base), 64'd6);
        chk("tlr_tms", tms_obs(base, 6), 64'b011111);
        bad = 0;
        for (int k = 0; k < 5; k++)
            if (rise_log[(base + k + 1) % 1024] - rise_log[(base + k) % 1024] != 4) bad++;
        chk("tlr_spacing", 64'(bad), 64'd0);
        chk("tlr_no_rsp", 64'(rsp_cnt - rbase), 64'd0);
        chk("tlr_tap_rti", 64'(tap_state), 64'(T_RTI));

        // 38-bit DR scan
        dr_cap = 38'h0_1234_5678;
        base = edges;
        send(1'b0, 6'd38, 38'h2A_AAAA_5555);
        wait_rsp(n);
        chk("dr_edges", 64'(edges - base), 64'd43);
        chk("dr_tms", tms_obs(base, 43), tms_exp(1'b0, 38));
        chk("dr_rsp_data", 64'(rsp_data), 64'h0_1234_5678);
        chk("dr_rsp_err", 64'(rsp_err), 64'd0);
        chk("dr_latency", 64'(cyc - rise_log[(base + 42) % 1024]), 64'd2);
        chk("dr_tck_low", 64'(tck), 64'd0);
        @(negedge clk);
        chk("dr_pulse_1cyc", 64'(rsp_valid), 64'd0);
        chk("dr_ready_after", 64'(cmd_ready), 64'd1);
        chk("dr_rsp_hold", 64'(rsp_data), 64'h0_1234_5678);
        chk("dr_update", 64'(dr_upd), 64'h2A_AAAA_5555);
        chk("dr_tap_rti", 64'(tap_state), 64'(T_RTI));

        // 10-bit IR scan
        wait_ready("ir_ready");
        base = edges;
        send(1'b1, 6'd10, 38'h00E);
        wait_rsp(n);
        chk("ir_edges", 64'(edges - base), 64'd16);
        chk("ir_tms", tms_obs(base, 16), tms_exp(1'b1, 10));
        chk("ir_rsp_data", 64'(rsp_data), 64'h1);
        chk("ir_rsp_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        chk("ir_update", 64'(ir_q), 64'h00E);

        // illegal commands
        for (int k = 0; k < 3; k++) begin
            wait_ready("ill_ready");
            base = edges;
            send(ill_ir[k], ill_len[k], 38'h3F_FFFF_FFFF);
            wait_rsp(n);
            chk("ill_latency", 64'(n), 64'd1);
            chk("ill_err", 64'(rsp_err), 64'd1);
            chk("ill_data", 64'(rsp_data), 64'd0);
            chk("ill_no_tck", 64'(edges - base), 64'd0);
        end

        // reset in the middle of a DR scan (during shift bit 10)
        wait_ready("mid_ready");
        base = edges; rbase = rsp_cnt;
        send(1'b0, 6'd38, 38'h15_5555_AAAA);
        n = 0;
        while ((edges - base) < 14 && n < 1000) begin @(negedge clk); n++; end
        chk("mid_reached_bit10", 64'((edges - base) >= 14), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("mid_tck", 64'(tck), 64'd0);
        chk("mid_tms", 64'(tms), 64'd1);
        chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_ready_low", 64'(cmd_ready), 64'd0);
        base = edges;
        wait_ready("mid_tlr_ready");
        $display("txn a: reset mid-scan, %0d recovery edges", edges - base);
        chk("mid_tlr_edges", 64'(edges - base), 64'd6);
        chk("mid_tlr_tms", tms_obs(base, 6), 64'b011111);
        chk("mid_no_rsp", 64'(rsp_cnt - rbase), 64'd0);
        chk("mid_tap_rti", 64'(tap_state), 64'(T_RTI));

        // back-to-back on instance b (CLK_DIV=1), cmd_valid held high
        n = 0;
        while (!b_cmd_ready && n < 1000) begin @(negedge clk); n++; end
        chk("b_ready", 64'(b_cmd_ready), 64'd1);
        base = b_edges; rbase = b_rsp_cnt;
        b_cmd_ir = 1'b0; b_cmd_len = 6'd4; b_cmd_data = 38'hA; b_cmd_valid = 1'b1;
        @(posedge clk); #1;
        $display("txn b: ir=0 len=4 data=a");
        b_cmd_len = 6'd1; b_cmd_data = 38'h1;
        n = 0;
        do begin @(negedge clk); n++; end while (!b_rsp_valid && n < 1000);
        chk("b_rsp1_seen", 64'(b_rsp_valid), 64'd1);
        chk("b_rsp1_edges", 64'(b_edges - base), 64'd9);
        chk("b_rsp1_err", 64'(b_rsp_err), 64'd0);
        base = b_edges;
        n = 0;
        while (!b_cmd_ready && n < 100) begin @(negedge clk); n++; end
        ready_cycles = 0;
        while (b_cmd_ready && ready_cycles < 100) begin @(negedge clk); ready_cycles++; end
        b_cmd_valid = 1'b0;
        $display("txn b: ir=0 len=1 data=1 (cmd_ready high %0d cycle(s))", ready_cycles);
        chk("b_ready_gap", 64'(ready_cycles >= 1), 64'd1);
        n = 0;
        do begin @(negedge clk); n++; end while (!b_rsp_valid && n < 1000);
        chk("b_rsp2_seen", 64'(b_rsp_valid), 64'd1);
        chk("b_rsp2_edges", 64'(b_edges - base), 64'd6);
        chk("b_rsp2_data", 64'(b_rsp_data), 64'd0);
        @(negedge clk);
        chk("b_rsp_count", 64'(b_rsp_cnt - rbase), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- Host-side JTAG scan engine: generates TCK/TMS/TDI into an IEEE 1149.1 TAP and captures TDO.
- Executes one IR or DR scan per command, up to 38 bits, which covers the debug slave's 38-bit shift register.
- Used in simulation benches and on-chip self-test paths to drive the Nios II debug slave from the tester side.
- Commands and responses use a valid/ready interface in the system clock domain.

Parameters:
- CLK_DIV, 2, clk cycles per TCK half-period (minimum 1); one TCK period = 2*CLK_DIV clk cycles.
- DR_WIDTH, 38, maximum scan length and width of the data buses.
- IR_WIDTH, 10, maximum legal IR scan length.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine can accept a command.
- cmd_ir  in  1  1 = IR scan, 0 = DR scan.
- cmd_len  in  6  number of bits to shift.
- cmd_data  in  DR_WIDTH  TDI data, shifted LSB first.
- rsp_valid  out  1  single-cycle pulse when a scan completes.
- rsp_data  out  DR_WIDTH  captured TDO bits, right-justified.
- rsp_err  out  1  qualifies rsp_valid: the command was illegal.
- tck  out  1  JTAG clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to the TAP.
- tdo  in  1  JTAG data from the TAP.

Behaviour:
- Interface: one clock, clk; reset_n is synchronous and active-low.
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0.
- TCK timing:
  - tck is produced by a counter on clk: low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - tms and tdi change only in the clk cycle where tck falls, or when tck is first started from idle.
  - tdo is sampled in the clk cycle where tck rises.
- Shadow TAP state: the FSM tracks the TAP state on each tck rising edge.
- FSM states: TLR_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RSP.
- TLR_SEQ:
  - Entered after every reset.
  - Issues 5 tck rising edges with tms=1, then 1 edge with tms=0, which lands the TAP in Run-Test/Idle.
  - Then goes to IDLE.
- IDLE:
  - tck held 0, tms=0.
  - cmd_ready=1 only in this state.
  - A command is accepted on cmd_valid & cmd_ready; cmd_ready drops the next cycle.
- Legality check:
  - A command is illegal if cmd_len=0, or cmd_len>DR_WIDTH, or (cmd_ir=1 and cmd_len>IR_WIDTH).
  - Illegal command: no tck activity; rsp_valid=1 and rsp_err=1 on the cycle after acceptance; rsp_data=0; returns to IDLE.
- DR scan TMS sequence: 1 (Select-DR), 0 (Capture), 0 (Shift).
  - The next cmd_len edges shift data; tms=0 on all but the last, tms=1 on the last (Exit1).
  - Then 1 (Update), then 0 (Run-Test/Idle).
  - Total edges = cmd_len+5.
- IR scan TMS sequence: 1, 1 (Select-IR), 0, 0, shift cmd_len bits (last with tms=1), 1, 0.
  - Total edges = cmd_len+6.
- TDI data: tdi presents cmd_data[i] for shift edge i. Outside the shift phase tdi=0.
- TDO capture:
  - tdo sampled at shift edge i goes to rsp_data[i].
  - Bits at cmd_len and above are 0.
- Response timing:
  - tck returns to 0 after the final edge.
  - rsp_valid pulses one cycle, CLK_DIV clk cycles after the final rising edge, with rsp_err=0.
  - rsp_data holds its value until the next response.
  - cmd_ready rises the cycle after rsp_valid.
- Command inputs: cmd_* are sampled only at acceptance; later changes have no effect.
- Reset mid-scan:
  - Outputs return to reset values in the next cycle and the scan is abandoned.
  - No rsp_valid is issued for the abandoned scan.
  - TLR_SEQ repeats before cmd_ready rises.
- Back-to-back commands: cmd_valid held high does not skip IDLE. Minimum 1 cycle of cmd_ready per command.

Test Plan:
- Reset sequence, CLK_DIV=2:
  - Release reset_n → 6 tck rising edges spaced 4 clk apart.
  - tms=1,1,1,1,1,0 at those edges.
  - cmd_ready=1 afterwards.
  - No rsp_valid.
- DR scan:
  - Bench TAP model preloads DR capture 38'h0_1234_5678.
  - Command cmd_ir=0, len=38, data=38'h2A_AAAA_5555.
  - Expect exactly 43 edges, rsp_data=38'h0_1234_5678, rsp_err=0.
  - Model's updated DR = 38'h2A_AAAA_5555.
- IR scan:
  - Command cmd_ir=1, len=10, data=10'h00E.
  - Expect 16 edges, model IR=10'h00E.
  - rsp_data = IR capture value 10'b0000000001.
- Illegal commands:
  - len=0, then len=11 with cmd_ir=1, then len=39.
  - Each gives rsp_valid&rsp_err one cycle after acceptance, tck stays 0, rsp_data=0.
- Reset mid-scan:
  - Drop reset_n for 1 cycle during shift bit 10 of a 38-bit DR scan.
  - Expect tck=0, tms=1, no rsp_valid.
  - Full 6-edge TLR sequence follows; model TAP ends in Run-Test/Idle.
- Back-to-back, CLK_DIV=1:
  - Two queued DR scans of len 4 and 1.
  - Expect 9 then 6 edges and two rsp_valid pulses.
  - cmd_ready high for at least 1 cycle between the two scans.
